// File: rtl/gf_div.sv
// gf_div: sequential GF(2^WIDTH) divider, out = in_1 / in_2.
//
// The divisor is inverted by square-and-multiply (Fermat): in_2^(2^WIDTH-2) is
// built up over WIDTH-1 iteration cycles, then one final multiply by the
// dividend produces the quotient.
//
// Timing: the edge that accepts i_start is followed by WIDTH-1 iteration
// cycles and one final cycle. o_done therefore rises on the WIDTH+1-th rising
// edge, counting the accepting edge as the first.
//
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_rst    synchronous active-high reset, wins over everything
//   i_start  operation request, sampled only while idle
//   in_1     dividend, captured on the accepting edge
//   in_2     divisor, captured on the accepting edge
//   out      registered quotient, held until the next result or reset
//   o_done   one-cycle pulse, out and o_err valid
//   o_busy   high while an operation is in flight (low in the o_done cycle)
//   o_err    divide-by-zero flag, updated with o_done and held
module gf_div #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH:0]   POLY  = 9'h11B
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic [WIDTH-1:0] out,
  output logic             o_done,
  output logic             o_busy,
  output logic             o_err
);

  localparam int          W       = int'(WIDTH);
  localparam int unsigned CntW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StIter, StFinal} state_e;

  // Shift-and-add multiply with the reduction folded into every shift.
  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[WIDTH-2:0], 1'b0} ^ (t[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
    end
    return p;
  endfunction

  // Squaring is linear over GF(2): spread the bits to even positions, then
  // fold the upper half back down with POLY from the top bit downwards.
  function automatic logic [WIDTH-1:0] gf_sqr(input logic [WIDTH-1:0] a);
    logic [2*WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      w[2*i] = a[i];
    end
    for (int i = 2 * W - 2; i >= W; i--) begin
      if (w[i]) w[i-W +: WIDTH+1] = w[i-W +: WIDTH+1] ^ POLY;
    end
    return w[WIDTH-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] sq_q, sq_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Arithmetic units: one squarer, two multipliers.
  logic [WIDTH-1:0] sq_next;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] quot;

  always_comb begin
    sq_next  = gf_sqr(sq_q);
    acc_next = gf_mul(acc_q, sq_next);
    quot     = gf_mul(acc_q, a_q);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_start) state_d = StIter;
      StIter:  if (cnt_q == CntLast) state_d = StFinal;
      StFinal: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    o_busy = (state_q != StIdle);
  end

  // Datapath next-state.
  always_comb begin
    a_d    = a_q;
    sq_d   = sq_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    out_d  = out_q;
    err_d  = err_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          a_d    = in_1;
          sq_d   = in_2;
          acc_d  = WIDTH'(1);
          cnt_d  = '0;
          zero_d = (in_2 == '0);
        end
      end
      StIter: begin
        // After k cycles sq = b^(2^k) and acc = b^(2^(k+1)-2).
        sq_d  = sq_next;
        acc_d = acc_next;
        cnt_d = cnt_q + CntW'(1);
      end
      StFinal: begin
        out_d  = zero_q ? '0 : quot;
        err_d  = zero_q;
        done_d = 1'b1;
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q    <= '0;
      sq_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      out_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      a_q    <= a_d;
      sq_q   <= sq_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      out_q  <= out_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign out    = out_q;
  assign o_done = done_q;
  assign o_err  = err_q;

endmodule
